// File: rtl/icache_fetch_if.sv
// Fetch-side handshake and refill word port of the instruction cache, grouped as one bundle.
// The cache takes the slave modport; the core/memory environment takes the master modport.
interface icache_fetch_if #(
  parameter int unsigned W = 32
) ();
  logic         instrreq;
  logic [W-1:0] instradr;
  logic [W-1:0] instrF;
  logic         hit;
  logic         abort;
  logic         memreq;
  logic [W-1:0] memadr;
  logic [W-1:0] memrdata;
  logic         memack;

  modport master (
    output instrreq, instradr, memrdata, memack,
    input  instrF, hit, abort, memreq, memadr
  );

  modport slave (
    input  instrreq, instradr, memrdata, memack,
    output instrF, hit, abort, memreq, memadr
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache; misses refill a full line in word order.
// Defining ICACHE_STATS_EN adds saturating hit/miss counter outputs.
module icache_fetch #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned W          = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  icache_fetch_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hitcnt_o,
  output logic [31:0]   misscnt_o
`endif
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = W - 2 - OffW - IdxW;
  localparam int unsigned Lo   = 2 + OffW;

  typedef enum logic [1:0] {StIdle, StLookup, StRefill, StResp} state_e;

  state_e            state_q, state_d;
  logic [W-1:2]      reqadr_q, reqadr_d;
  logic [W-1:0]      instr_q, instr_d;
  logic [W-1:0]      memadr_q, memadr_d;
  logic              hit_q, hit_d;
  logic              abort_q, abort_d;
  logic              memreq_q, memreq_d;
  logic [OffW-1:0]   cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;

  logic [TagW-1:0]   tag_q  [SETS];
  logic [W-1:0]      data_q [SETS*LINE_WORDS];

  logic [OffW-1:0]   req_off;
  logic [IdxW-1:0]   req_idx;
  logic [TagW-1:0]   req_tag;
  logic              lookup_hit;
  logic              fill_we;
  logic              fill_last;

  assign req_off    = reqadr_q[Lo-1:2];
  assign req_idx    = reqadr_q[Lo+IdxW-1:Lo];
  assign req_tag    = reqadr_q[W-1:Lo+IdxW];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // memack is only honoured while a word request is actually outstanding
  assign fill_we    = (state_q == StRefill) && memreq_q && bus.memack;
  assign fill_last  = &cnt_q;

  always_comb begin
    state_d  = state_q;
    reqadr_d = reqadr_q;
    instr_d  = instr_q;
    memadr_d = memadr_q;
    hit_d    = hit_q;
    abort_d  = abort_q;
    memreq_d = memreq_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (bus.instrreq) begin
          reqadr_d = bus.instradr[W-1:2];
          abort_d  = 1'b1;
          hit_d    = 1'b0;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        if (lookup_hit) begin
          instr_d = data_q[{req_idx, req_off}];
          hit_d   = 1'b1;
          abort_d = 1'b0;
          state_d = StResp;
        end else begin
          memreq_d = 1'b1;
          memadr_d = {req_tag, req_idx, {OffW{1'b0}}, 2'b00};
          cnt_d    = '0;
          state_d  = StRefill;
        end
      end
      StRefill: begin
        if (fill_we) begin
          if (fill_last) begin
            valid_d[req_idx] = 1'b1;
            memreq_d         = 1'b0;
            state_d          = StLookup;
          end else begin
            cnt_d    = cnt_q + OffW'(1);
            memadr_d = memadr_q + W'(4);
          end
        end
      end
      StResp: begin
        if (!bus.instrreq) begin
          hit_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      reqadr_q <= '0;
      instr_q  <= '0;
      memadr_q <= '0;
      hit_q    <= 1'b0;
      abort_q  <= 1'b0;
      memreq_q <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      reqadr_q <= reqadr_d;
      instr_q  <= instr_d;
      memadr_q <= memadr_d;
      hit_q    <= hit_d;
      abort_q  <= abort_d;
      memreq_q <= memreq_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  // Tag/data storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_q[{req_idx, cnt_q}] <= bus.memrdata;
      if (fill_last) begin
        tag_q[req_idx] <= req_tag;
      end
    end
  end

  assign bus.instrF = instr_q;
  assign bus.hit    = hit_q;
  assign bus.abort  = abort_q;
  assign bus.memreq = memreq_q;
  assign bus.memadr = memadr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hitcnt_q, misscnt_q;
  logic        from_refill_q;

  // The guaranteed re-lookup after a refill is not counted as a hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hitcnt_q      <= '0;
      misscnt_q     <= '0;
      from_refill_q <= 1'b0;
    end else begin
      from_refill_q <= (state_q == StRefill);
      if (state_q == StLookup) begin
        if (lookup_hit && !from_refill_q && (hitcnt_q != '1)) begin
          hitcnt_q <= hitcnt_q + 32'd1;
        end
        if (!lookup_hit && (misscnt_q != '1)) begin
          misscnt_q <= misscnt_q + 32'd1;
        end
      end
    end
  end

  assign hitcnt_o  = hitcnt_q;
  assign misscnt_o = misscnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed fetch sequences against a cache-content model.
// Build with ICACHE_STATS_EN defined to also check the hit/miss counters.
module tb_icache_fetch;
  localparam int unsigned LW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  icache_fetch_if #(.W(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hitcnt, misscnt;
`endif

  icache_fetch #(
    .SETS      (64),
    .LINE_WORDS(LW),
    .W         (32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hitcnt_o (hitcnt),
    .misscnt_o(misscnt)
`endif
  );

  // Model: which line each index holds, plus the expectations of the request in flight.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] exp_base;
  logic [31:0] exp_instr;
  int          words_acked;
  logic [31:0] seen_adr[$];
  logic [31:0] last_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_flags", {29'd0, bus.hit, bus.abort, bus.memreq}, 32'd0);
      check("rst_memadr", bus.memadr, 32'd0);
      check("rst_instr", bus.instrF, 32'd0);
    end else begin
      check("hit_abort_excl", {31'd0, bus.hit & bus.abort}, 32'd0);
      if (bus.hit) check("instr_word", bus.instrF, exp_instr);
      if (bus.memreq) check("refill_adr", bus.memadr, exp_base + 32'(4 * words_acked));
    end
  end

  // One clock of memory response; entered and left at posedge+1.
  task automatic mem_cycle(input bit stall);
    @(negedge clk);
    if (bus.memreq && !stall) begin
      bus.memack   = 1'b1;
      bus.memrdata = 32'h1000 + exp_base + 32'(4 * words_acked);
      seen_adr.push_back(bus.memadr);
    end else begin
      bus.memack = 1'b0;
    end
    @(posedge clk);
    #1;
    if (bus.memack) words_acked++;
    bus.memack = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] adr, input int stall_word, input int stall_len,
                       input string name);
    int          idx = int'(adr[9:4]);
    logic [21:0] tg  = adr[31:10];
    bit          miss;
    bit          got = 1'b0;
    int          edges = 0;
    int          stalled = 0;
    bit          st;
    miss        = !(m_valid[idx] && (m_tag[idx] == tg));
    exp_base    = {adr[31:4], 4'h0};
    exp_instr   = 32'h1000 + {adr[31:2], 2'b00};
    words_acked = 0;
    bus.instrreq = 1'b1;
    bus.instradr = adr;
    while (!got && edges < 100) begin
      st = bus.memreq && (words_acked == stall_word) && (stalled < stall_len);
      if (st) stalled++;
      mem_cycle(st);
      edges++;
      got = bus.hit;
    end
    last_instr = bus.instrF;
    check({name, "_done"}, {31'd0, got}, 32'd1);
    check({name, "_words"}, words_acked, miss ? LW : 0);
    check({name, "_latency"}, edges, miss ? 2 + LW + 1 + stall_len : 2);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    // Address changes outside IDLE must not disturb the held response.
    bus.instradr = adr ^ 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_hold_hit"}, {30'd0, bus.hit, bus.abort}, 32'd2);
    bus.instrreq = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_release"}, {30'd0, bus.hit, bus.abort}, 32'd0);
  endtask

  initial begin
    int guard;
    bus.instrreq = 1'b0;
    bus.instradr = '0;
    bus.memack   = 1'b0;
    bus.memrdata = '0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_flags", {29'd0, bus.hit, bus.abort, bus.memreq}, 32'd0);

    seen_adr.delete();
    fetch(32'h0000_0040, -1, 0, "cold");
    check("cold_instr", last_instr, 32'h0000_1040);
    check("cold_adr0", seen_adr.size() > 0 ? seen_adr[0] : 32'hX, 32'h0000_0040);
    check("cold_adr3", seen_adr.size() > 3 ? seen_adr[3] : 32'hX, 32'h0000_004C);

    seen_adr.delete();
    fetch(32'h0000_0048, -1, 0, "warm");
    check("warm_instr", last_instr, 32'h0000_1048);
    check("warm_nomem", seen_adr.size(), 32'd0);

    seen_adr.delete();
    fetch(32'h0000_0440, -1, 0, "conflict");
    check("conflict_instr", last_instr, 32'h0000_1440);
    check("conflict_adr0", seen_adr.size() > 0 ? seen_adr[0] : 32'hX, 32'h0000_0440);

`ifdef ICACHE_STATS_EN
    check("stats_miss", misscnt, 32'd2);
    check("stats_hit", hitcnt, 32'd1);
`endif

    seen_adr.delete();
    fetch(32'h0000_0040, 1, 5, "stall");
    check("stall_instr", last_instr, 32'h0000_1040);
    check("stall_adr1", seen_adr.size() > 1 ? seen_adr[1] : 32'hX, 32'h0000_0044);

    // Reset two words into a refill of 0x80.
    exp_base     = 32'h0000_0080;
    exp_instr    = 32'h0000_1080;
    words_acked  = 0;
    bus.instrreq = 1'b1;
    bus.instradr = 32'h0000_0080;
    guard = 0;
    while (words_acked < 2 && guard < 20) begin
      mem_cycle(1'b0);
      guard++;
    end
    check("midrst_acks", words_acked, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async", {29'd0, bus.hit, bus.abort, bus.memreq}, 32'd0);
    bus.instrreq = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fetch(32'h0000_0040, -1, 0, "postrst");
    check("postrst_instr", last_instr, 32'h0000_1040);
    fetch(32'h0000_0084, -1, 0, "partial");
    check("partial_instr", last_instr, 32'h0000_1084);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
